// File: rtl/svc_rv_pipe_skid.sv
// Two-entry valid/ready skid buffer for a pipeline stage boundary.
// ready_o and valid_o/data_o come only from flops, so no ready path crosses the boundary.

`ifndef SVC_UNUSED
`define SVC_UNUSED(sig) logic unusedSignals; assign unusedSignals = |(sig);
`endif

module svc_rv_pipe_skid #(
    parameter int WIDTH = 32,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    input  logic             flush_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    generate
        if (REG) begin : g_reg
            state_t           state_q, state_d;
            logic [WIDTH-1:0] out_data_q, out_data_d;
            logic [WIDTH-1:0] skid_data_q, skid_data_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q     <= EMPTY;
                    out_data_q  <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q     <= state_d;
                    out_data_q  <= out_data_d;
                    skid_data_q <= skid_data_d;
                end
            end

            // Flush only clears occupancy; payload registers keep their last contents.
            always_comb begin
                state_d     = state_q;
                out_data_d  = out_data_q;
                skid_data_d = skid_data_q;
                if (flush_i) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (valid_i) begin
                                out_data_d = data_i;
                                state_d    = BUSY;
                            end
                        end
                        BUSY: begin
                            if (valid_i && ready_i) begin
                                out_data_d = data_i;
                            end else if (valid_i) begin
                                skid_data_d = data_i;
                                state_d     = FULL;
                            end else if (ready_i) begin
                                state_d = EMPTY;
                            end
                        end
                        FULL: begin
                            if (ready_i) begin
                                out_data_d = skid_data_q;
                                state_d    = BUSY;
                            end
                        end
                        default: begin
                            state_d = EMPTY;
                        end
                    endcase
                end
            end

            assign ready_o = (state_q != FULL);
            assign valid_o = (state_q != EMPTY);
            assign data_o  = out_data_q;
        end else begin : g_pass
            assign valid_o = valid_i;
            assign data_o  = data_i;
            assign ready_o = ready_i;

            `SVC_UNUSED({clk, rst, flush_i})
        end
    endgenerate

endmodule

// File: tb/tb_svc_rv_pipe_skid.sv
// Scoreboard bench for svc_rv_pipe_skid: directed scenarios plus random traffic against
// a queue-based occupancy model; also checks the REG=0 passthrough build.

module tb_svc_rv_pipe_skid;

    typedef struct {
        logic        valid;
        logic        ready;
        logic [31:0] data;
    } cyc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o, valid_o;
    logic [31:0] data_o;

    logic        pt_valid_i = 1'b0;
    logic [31:0] pt_data_i = '0;
    logic        pt_ready_i = 1'b0;
    logic        pt_ready_o, pt_valid_o;
    logic [31:0] pt_data_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];
    cyc_t        cyc_q[$];

    svc_rv_pipe_skid #(.WIDTH(32), .REG(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i), .flush_i(flush_i)
    );

    svc_rv_pipe_skid #(.WIDTH(32), .REG(1'b0)) dut_pt (
        .clk(clk), .rst(rst), .valid_i(pt_valid_i), .data_i(pt_data_i), .ready_o(pt_ready_o),
        .valid_o(pt_valid_o), .data_o(pt_data_o), .ready_i(pt_ready_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle and advance the model: a word is taken when fewer than two are held.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
        cyc_t        e;
        int          occ;
        logic [31:0] junk;
        @(posedge clk);
        #1;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        occ     = model_q.size();
        e.valid = (occ > 0);
        e.ready = (occ < 2);
        e.data  = '0;
        if (occ > 0) e.data = model_q[0];
        cyc_q.push_back(e);
        if (f) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            if (r && occ > 0) junk = model_q.pop_front();
            if (v && occ < 2) begin
                model_q.push_back(d);
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic midCycleReset();
        @(negedge clk);
        #1;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        #1;
        checkBit("async_rst_valid", valid_o, 1'b0);
        checkBit("async_rst_ready", ready_o, 1'b1);
        checkOutput("async_rst_data", data_o, 32'h0);
        model_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle handshake check, plus in-order scoreboard pop on each delivery.
    cyc_t        mon_e;
    logic [31:0] mon_w;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            checkBit("ready_o", ready_o, mon_e.ready);
            checkBit("valid_o", valid_o, mon_e.valid);
            if (mon_e.valid && valid_o) checkOutput("data_o", data_o, mon_e.data);
            if (valid_o && ready_i && !flush_i && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow actual=0x%08h expected=none at %0t", data_o, $time);
                end else begin
                    mon_w = exp_q.pop_front();
                    checkOutput("sb_order", data_o, mon_w);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkBit("reset_valid", valid_o, 1'b0);
        checkBit("reset_ready", ready_o, 1'b1);
        checkOutput("reset_data", data_o, 32'h0);
        rst = 1'b0;

        $display("[TB] stream");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h10 + i, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] single stall");
        applyStimulus(1'b1, 32'hA0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hA1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA3, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hA3, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hA4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] long stall");
        applyStimulus(1'b1, 32'hB0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hB1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hB2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hB2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] flush in full");
        applyStimulus(1'b1, 32'hE0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hE1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hEE, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'hC0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] async reset");
        applyStimulus(1'b1, 32'hF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hF1, 1'b0, 1'b0);
        midCycleReset();
        applyStimulus(1'b1, 32'hD0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("sb_drain", exp_q.size(), 32'd0);

        $display("[TB] passthrough");
        for (int i = 0; i < 24; i++) begin
            pt_valid_i = 1'($urandom_range(0, 1));
            pt_ready_i = 1'($urandom_range(0, 1));
            pt_data_i  = $urandom;
            #1;
            checkBit("pt_valid", pt_valid_o, pt_valid_i);
            checkBit("pt_ready", pt_ready_o, pt_ready_i);
            checkOutput("pt_data", pt_data_o, pt_data_i);
            #2;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
